// File: rtl/ddma_pkg.sv
// ddma_pkg: shared definitions for the DMA-to-NoC engine.
//   state_t   : engine FSM states (HEADER is only reached when the
//               DDMA_HEADER_EN macro is defined at build time)
//   ST_*      : bit positions inside status_out / irq_out
package ddma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    SEND   = 3'd3,
    DONE   = 3'd4,
    HEADER = 3'd5
  } state_t;

  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_ERROR   = 2;
  localparam int ST_DROPPED = 3;
  localparam int ST_RSVD    = 4;

endpackage

// File: rtl/ddma_serializer.sv
// ddma_serializer: splits one memory word into MEMORY_BUS_WIDTH/FLIT_WIDTH
// flits, least-significant flit first, advancing on each valid/ready
// handshake.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   load         : capture word_in and start presenting its first flit
//   word_in      : memory word to serialize
//   ready        : downstream ready; a flit moves when valid && ready
//   flit         : current flit (held stable while not accepted)
//   valid        : a flit is being presented
//   last         : the presented flit is the final one of the word
module ddma_serializer #(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        load,
  input  logic [MEMORY_BUS_WIDTH-1:0] word_in,
  input  logic                        ready,
  output logic [FLIT_WIDTH-1:0]       flit,
  output logic                        valid,
  output logic                        last
);

  localparam int NFLITS = MEMORY_BUS_WIDTH / FLIT_WIDTH;
  localparam int CW     = (NFLITS > 1) ? $clog2(NFLITS) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NFLITS - 1);
  localparam logic [CW-1:0] ONE_IDX  = CW'(1);

  logic [MEMORY_BUS_WIDTH-1:0] shift_p0;
  logic [CW-1:0]               idx_p0;
  logic                        vld_p0;

  // Stage p0: shift register; the low flit is always the one on the wire.
  // After the last flit is accepted the register is left untouched so the
  // output does not toggle needlessly while idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      shift_p0 <= '0;
      idx_p0   <= '0;
      vld_p0   <= 1'b0;
    end else if (load) begin
      shift_p0 <= word_in;
      idx_p0   <= '0;
      vld_p0   <= 1'b1;
    end else if (vld_p0 && ready) begin
      if (idx_p0 == LAST_IDX) begin
        vld_p0 <= 1'b0;
      end else begin
        shift_p0 <= shift_p0 >> FLIT_WIDTH;
        idx_p0   <= idx_p0 + ONE_IDX;
      end
    end
  end

  assign flit  = shift_p0[FLIT_WIDTH-1:0];
  assign valid = vld_p0;
  assign last  = (idx_p0 == LAST_IDX);

endmodule

// File: rtl/ddma_engine.sv
// ddma_engine: reads a block of memory words and streams them onto a NoC
// link as flits.
//   clock, reset      : rising-edge clock, synchronous active-high reset
//   addr_in           : word address of the first word (latched on cmd_in)
//   nbytes_in         : transfer length in bytes (latched on cmd_in)
//   cmd_in            : one-cycle start pulse
//   status_out        : {0, dropped, error, done, busy}
//   irq_out           : one-cycle pulses at the done/error/dropped positions
//   mem_addr_out      : memory word read address
//   mem_rd_out        : read strobe, data returns one cycle later
//   mem_data_in       : memory read data
//   flit_out          : NoC flit
//   flit_valid_out    : flit valid
//   flit_ready_in     : NoC ready
// Build option: define DDMA_HEADER_EN to prefix each transfer with one
// header flit carrying the word count (truncated to FLIT_WIDTH bits).
// MEMORY_BUS_WIDTH must be 32 or 64 and a multiple of FLIT_WIDTH.
module ddma_engine
  import ddma_pkg::*;
#(
  parameter int MEMORY_BUS_WIDTH = 32,
  parameter int FLIT_WIDTH       = 16
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [MEMORY_BUS_WIDTH-3:0] addr_in,
  input  logic [MEMORY_BUS_WIDTH-3:0] nbytes_in,
  input  logic                        cmd_in,
  output logic [4:0]                  status_out,
  output logic [4:0]                  irq_out,
  output logic [MEMORY_BUS_WIDTH-3:0] mem_addr_out,
  output logic                        mem_rd_out,
  input  logic [MEMORY_BUS_WIDTH-1:0] mem_data_in,
  output logic [FLIT_WIDTH-1:0]       flit_out,
  output logic                        flit_valid_out,
  input  logic                        flit_ready_in
);

  localparam int AW             = MEMORY_BUS_WIDTH - 2;
  localparam int BYTES_PER_WORD = MEMORY_BUS_WIDTH / 8;
  localparam int BSH            = $clog2(BYTES_PER_WORD);
  localparam logic [AW-1:0] ONE_W = AW'(1);

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   words_q;
  logic            busy_q;
  logic            done_q;
  logic            error_q;
  logic            dropped_q;
  logic [4:0]      irq_q;

  logic            len_bad;
  logic [AW-1:0]   words_in;
  logic            ser_load;
  logic            ser_valid;
  logic            ser_last;
  logic            word_done;
  logic [FLIT_WIDTH-1:0] ser_flit;

`ifdef DDMA_HEADER_EN
  logic                  hdr_vld_q;
  logic [FLIT_WIDTH-1:0] hdr_flit_q;

  // Word count as it appears on the wire: low FLIT_WIDTH bits, zero-extended
  // when the flit is wider than the count.
  function automatic logic [FLIT_WIDTH-1:0] hdr_of(input logic [AW-1:0] words);
    logic [AW+FLIT_WIDTH-1:0] ext;
    ext = {{FLIT_WIDTH{1'b0}}, words};
    return ext[FLIT_WIDTH-1:0];
  endfunction
`endif

  // A length is only usable if it is a non-zero whole number of words.
  assign len_bad   = (nbytes_in == '0) || (nbytes_in[BSH-1:0] != '0);
  assign words_in  = nbytes_in >> BSH;
  // Read data is on mem_data_in during WAIT (one cycle after the strobe).
  assign ser_load  = (state == WAIT);
  assign word_done = ser_valid && flit_ready_in && ser_last;

  ddma_serializer #(
    .MEMORY_BUS_WIDTH (MEMORY_BUS_WIDTH),
    .FLIT_WIDTH       (FLIT_WIDTH)
  ) u_serializer (
    .clock   (clock),
    .reset   (reset),
    .load    (ser_load),
    .word_in (mem_data_in),
    .ready   (flit_ready_in),
    .flit    (ser_flit),
    .valid   (ser_valid),
    .last    (ser_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      addr_q       <= '0;
      words_q      <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
      dropped_q    <= 1'b0;
      irq_q        <= '0;
      mem_rd_out   <= 1'b0;
      mem_addr_out <= '0;
`ifdef DDMA_HEADER_EN
      hdr_vld_q    <= 1'b0;
      hdr_flit_q   <= '0;
`endif
    end else begin
      irq_q      <= '0;
      mem_rd_out <= 1'b0;

      // A command arriving while a transfer runs is discarded but reported.
      if (cmd_in && busy_q) begin
        dropped_q          <= 1'b1;
        irq_q[ST_DROPPED]  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_in) begin
            done_q    <= 1'b0;
            dropped_q <= 1'b0;
            if (len_bad) begin
              error_q         <= 1'b1;
              irq_q[ST_ERROR] <= 1'b1;
            end else begin
              error_q <= 1'b0;
              busy_q  <= 1'b1;
              addr_q  <= addr_in;
              words_q <= words_in;
`ifdef DDMA_HEADER_EN
              hdr_vld_q  <= 1'b1;
              hdr_flit_q <= hdr_of(words_in);
              state      <= HEADER;
`else
              mem_rd_out   <= 1'b1;
              mem_addr_out <= addr_in;
              state        <= FETCH;
`endif
            end
          end
        end
`ifdef DDMA_HEADER_EN
        HEADER: begin
          if (flit_ready_in) begin
            hdr_vld_q    <= 1'b0;
            mem_rd_out   <= 1'b1;
            mem_addr_out <= addr_q;
            state        <= FETCH;
          end
        end
`endif
        FETCH: state <= WAIT;
        WAIT:  state <= SEND;
        SEND: begin
          if (word_done) begin
            addr_q  <= addr_q + ONE_W;
            words_q <= words_q - ONE_W;
            if (words_q > ONE_W) begin
              mem_rd_out   <= 1'b1;
              mem_addr_out <= addr_q + ONE_W;
              state        <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          busy_q         <= 1'b0;
          done_q         <= 1'b1;
          irq_q[ST_DONE] <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign status_out[ST_BUSY]    = busy_q;
  assign status_out[ST_DONE]    = done_q;
  assign status_out[ST_ERROR]   = error_q;
  assign status_out[ST_DROPPED] = dropped_q;
  assign status_out[ST_RSVD]    = 1'b0;
  assign irq_out                = irq_q;

`ifdef DDMA_HEADER_EN
  assign flit_out       = hdr_vld_q ? hdr_flit_q : ser_flit;
  assign flit_valid_out = hdr_vld_q | ser_valid;
`else
  assign flit_out       = ser_flit;
  assign flit_valid_out = ser_valid;
`endif

endmodule

// File: tb/tb_ddma_engine.sv
// Testbench for ddma_engine (default 32-bit memory, 16-bit flits).
module tb_ddma_engine;

`ifdef DDMA_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [29:0] DROP_ADDR = 30'h40;

  logic        clock;
  logic        reset;
  logic [29:0] addr_in;
  logic [29:0] nbytes_in;
  logic        cmd_in;
  logic [4:0]  status_out;
  logic [4:0]  irq_out;
  logic [29:0] mem_addr_out;
  logic        mem_rd_out;
  logic [31:0] mem_data_in = '0;
  logic [15:0] flit_out;
  logic        flit_valid_out;
  logic        flit_ready_in;

  ddma_engine #(.MEMORY_BUS_WIDTH(32), .FLIT_WIDTH(16)) dut (
    .clock          (clock),
    .reset          (reset),
    .addr_in        (addr_in),
    .nbytes_in      (nbytes_in),
    .cmd_in         (cmd_in),
    .status_out     (status_out),
    .irq_out        (irq_out),
    .mem_addr_out   (mem_addr_out),
    .mem_rd_out     (mem_rd_out),
    .mem_data_in    (mem_data_in),
    .flit_out       (flit_out),
    .flit_valid_out (flit_valid_out),
    .flit_ready_in  (flit_ready_in)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int passes = 0;

  // Memory contents: explicit words, otherwise an address-derived pattern.
  logic [31:0] mem [logic [29:0]];
  function automatic logic [31:0] mem_word(input logic [29:0] a);
    if (mem.exists(a)) return mem[a];
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  always @(posedge clock) if (mem_rd_out) mem_data_in <= mem_word(mem_addr_out);

  // Observed traffic and expected traffic.
  logic [29:0] rd_q[$];
  logic [15:0] flit_q[$];
  logic [29:0] exp_rd[$];
  logic [15:0] exp_fl[$];
  bit          exp_err;
  int n_done, n_err, n_drop, n_bad;
  bit          hold_armed = 0;
  logic [15:0] hold_flit  = '0;

  // Monitor: samples on the falling edge, mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_rd_out) rd_q.push_back(mem_addr_out);
      if (flit_valid_out && flit_ready_in) flit_q.push_back(flit_out);
      if (irq_out[1]) n_done++;
      if (irq_out[2]) n_err++;
      if (irq_out[3]) n_drop++;
      if (irq_out[0] || irq_out[4]) n_bad++;
      if (hold_armed) begin
        checks++;
        if (flit_valid_out !== 1'b1 || flit_out !== hold_flit)
          $display("FAIL flit_hold: valid=%b flit=%h, required valid=1 flit=%h",
                   flit_valid_out, flit_out, hold_flit);
        else passes++;
      end
    end
    hold_armed = !reset && flit_valid_out && !flit_ready_in;
    hold_flit  = flit_out;
  end

  // Reference model: expected reads and flits from the transfer rules.
  task automatic build_model(input logic [29:0] a, input logic [29:0] nb);
    int unsigned n;
    logic [29:0] wa;
    logic [31:0] w;
    exp_rd.delete();
    exp_fl.delete();
    exp_err = (nb == 30'd0) || (nb % 4 != 0);
    if (!exp_err) begin
      n = nb / 4;
      if (HDR != 0) exp_fl.push_back(16'(n));
      for (int unsigned i = 0; i < n; i++) begin
        wa = a + 30'(i);
        w  = mem_word(wa);
        exp_rd.push_back(wa);
        exp_fl.push_back(w[15:0]);
        exp_fl.push_back(w[31:16]);
      end
    end
  endtask

  function automatic bit rd_ok();
    if (rd_q.size() != exp_rd.size()) return 0;
    foreach (rd_q[i]) if (rd_q[i] !== exp_rd[i]) return 0;
    return 1;
  endfunction

  function automatic bit fl_ok();
    if (flit_q.size() != exp_fl.size()) return 0;
    foreach (flit_q[i]) if (flit_q[i] !== exp_fl[i]) return 0;
    return 1;
  endfunction

  // Transfer driver. mode 0: ready always 1; 1: random ready;
  // 2: ready low for 5 cycles while the second payload flit is presented.
  bit          timed_out;
  int          first_lat;
  logic [15:0] stall_flit;
  logic        stall_vld;

  task automatic run_xfer(input logic [29:0] a, input logic [29:0] nb,
                          input int mode, input bit do_drop);
    int k;
    bit drop_done, bp_started;
    int bp_cnt;
    build_model(a, nb);
    rd_q.delete(); flit_q.delete();
    n_done = 0; n_err = 0; n_drop = 0; n_bad = 0;
    timed_out = 0; first_lat = -1; stall_flit = '0; stall_vld = 1'b0;
    k = 0; drop_done = 0; bp_started = 0; bp_cnt = 0;
    @(posedge clock); #1;
    cmd_in = 1'b1; addr_in = a; nbytes_in = nb;
    flit_ready_in = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      @(posedge clock); #1;
      k++;
      cmd_in = 1'b0; addr_in = 30'($urandom); nbytes_in = 30'($urandom);
      if (first_lat < 0 && flit_valid_out) first_lat = k;
      if (do_drop && !drop_done && flit_valid_out) begin
        cmd_in = 1'b1; addr_in = DROP_ADDR; nbytes_in = 30'd8; drop_done = 1;
      end
      case (mode)
        1: flit_ready_in = 1'($urandom_range(0, 1));
        2: begin
          if (!bp_started && flit_q.size() == HDR + 1) bp_started = 1;
          if (bp_started && bp_cnt < 5) begin
            flit_ready_in = 1'b0;
            bp_cnt++;
            if (bp_cnt == 5) begin stall_flit = flit_out; stall_vld = flit_valid_out; end
          end else flit_ready_in = 1'b1;
        end
        default: flit_ready_in = 1'b1;
      endcase
      if (n_done != 0 || n_err != 0) break;
      if (k >= 400) begin timed_out = 1; break; end
    end
    cmd_in = 1'b0; flit_ready_in = 1'b1;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (status_out !== 5'b0) $display("FAIL reset_status: got %b required 00000", status_out);
    else passes++;
    checks++;
    if (irq_out !== 5'b0) $display("FAIL reset_irq: got %b required 00000", irq_out);
    else passes++;
    checks++;
    if ({mem_rd_out, mem_addr_out, flit_valid_out, flit_out} !== '0)
      $display("FAIL reset_outputs: rd=%b addr=%h fv=%b flit=%h, required all 0",
               mem_rd_out, mem_addr_out, flit_valid_out, flit_out);
    else passes++;
    reset = 1'b0;
  endtask

  task automatic test_basic();
    run_xfer(30'h10, 30'd8, 0, 0);
    checks++;
    if (timed_out !== 1'b0) $display("FAIL basic_timeout: no completion, required done");
    else passes++;
    checks++;
    if (rd_ok() !== 1'b1) $display("FAIL basic_reads: got %0d reads, required %0d (0x10, 0x11)", rd_q.size(), exp_rd.size());
    else passes++;
    checks++;
    if (fl_ok() !== 1'b1) $display("FAIL basic_flits: got %0d flits, required %0d matching 5555 AAAA 5678 1234", flit_q.size(), exp_fl.size());
    else passes++;
    checks++;
    if (n_done !== 1) $display("FAIL basic_irq_done: got %0d pulse cycles, required 1", n_done);
    else passes++;
    checks++;
    if (status_out !== 5'b00010) $display("FAIL basic_status: got %b required 00010", status_out);
    else passes++;
    checks++;
    if (first_lat !== ((HDR != 0) ? 1 : 3)) $display("FAIL basic_latency: got %0d cycles required %0d", first_lat, (HDR != 0) ? 1 : 3);
    else passes++;
    checks++;
    if (n_bad !== 0) $display("FAIL basic_irq_reserved: got %0d pulses on bits 0/4, required 0", n_bad);
    else passes++;
  endtask

  task automatic test_backpressure();
    run_xfer(30'h10, 30'd8, 2, 0);
    checks++;
    if ({stall_vld, stall_flit} !== {1'b1, 16'hAAAA}) $display("FAIL bp_held_flit: got valid=%b flit=%h required valid=1 flit=aaaa", stall_vld, stall_flit);
    else passes++;
    checks++;
    if (fl_ok() !== 1'b1) $display("FAIL bp_flits: got %0d flits, required %0d unchanged sequence", flit_q.size(), exp_fl.size());
    else passes++;
    checks++;
    if (rd_ok() !== 1'b1) $display("FAIL bp_reads: got %0d reads, required %0d", rd_q.size(), exp_rd.size());
    else passes++;
    checks++;
    if (status_out !== 5'b00010) $display("FAIL bp_status: got %b required 00010", status_out);
    else passes++;
  endtask

  task automatic test_errors();
    logic [29:0] nb;
    for (int t = 0; t < 2; t++) begin
      nb = (t == 0) ? 30'd6 : 30'd0;
      run_xfer(30'h10, nb, 0, 0);
      checks++;
      if (rd_q.size() !== 0) $display("FAIL err_no_read: nbytes=%0d got %0d reads required 0", nb, rd_q.size());
      else passes++;
      checks++;
      if (n_err !== 1 || n_done !== 0) $display("FAIL err_irq: nbytes=%0d got err=%0d done=%0d required 1/0", nb, n_err, n_done);
      else passes++;
      checks++;
      if (status_out !== 5'b00100) $display("FAIL err_status: nbytes=%0d got %b required 00100", nb, status_out);
      else passes++;
    end
  endtask

  task automatic test_dropped();
    bit saw40;
    run_xfer(30'h10, 30'd8, 0, 1);
    saw40 = 0;
    foreach (rd_q[i]) if (rd_q[i] === DROP_ADDR) saw40 = 1;
    checks++;
    if (n_drop !== 1) $display("FAIL drop_irq: got %0d pulse cycles required 1", n_drop);
    else passes++;
    checks++;
    if (saw40 !== 1'b0 || rd_ok() !== 1'b1) $display("FAIL drop_reads: got %0d reads (0x40 read=%b) required %0d, no 0x40", rd_q.size(), saw40, exp_rd.size());
    else passes++;
    checks++;
    if (fl_ok() !== 1'b1 || n_done !== 1) $display("FAIL drop_transfer: got %0d flits done=%0d required %0d flits done=1", flit_q.size(), n_done, exp_fl.size());
    else passes++;
    checks++;
    if (status_out !== 5'b01010) $display("FAIL drop_status: got %b required 01010", status_out);
    else passes++;
  endtask

  task automatic test_reset_wrap();
    int k;
    rd_q.delete(); flit_q.delete();
    @(posedge clock); #1;
    cmd_in = 1'b1; addr_in = 30'h20; nbytes_in = 30'd16; flit_ready_in = 1'b1;
    @(posedge clock); #1;
    cmd_in = 1'b0;
    k = 0;
    while (!mem_rd_out && k < 10) begin @(posedge clock); #1; k++; end
    checks++;
    if (mem_rd_out !== 1'b1) $display("FAIL rst_fetch: got rd=%b required 1", mem_rd_out);
    else passes++;
    @(posedge clock); #1;           // now in WAIT
    reset = 1'b1;
    @(posedge clock); #1;
    checks++;
    if ({status_out, irq_out, mem_rd_out, mem_addr_out, flit_valid_out, flit_out} !== '0)
      $display("FAIL rst_mid_outputs: status=%b irq=%b rd=%b addr=%h fv=%b flit=%h required all 0",
               status_out, irq_out, mem_rd_out, mem_addr_out, flit_valid_out, flit_out);
    else passes++;
    reset = 1'b0;
    n_done = 0; flit_q.delete();
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (n_done !== 0 || status_out !== 5'b0 || flit_q.size() !== 0)
      $display("FAIL rst_abandon: done=%0d status=%b flits=%0d required 0/00000/0", n_done, status_out, flit_q.size());
    else passes++;
    run_xfer(30'h3FFFFFFF, 30'd8, 0, 0);
    checks++;
    if (rd_ok() !== 1'b1 || rd_q.size() != 2 || rd_q[rd_q.size()-1] !== 30'h0)
      $display("FAIL wrap_reads: got %0d reads required 0x3fffffff then 0x0", rd_q.size());
    else passes++;
    checks++;
    if (fl_ok() !== 1'b1 || status_out !== 5'b00010)
      $display("FAIL wrap_xfer: got %0d flits status=%b required %0d flits status 00010", flit_q.size(), status_out, exp_fl.size());
    else passes++;
  endtask

  task automatic test_random();
    logic [29:0] a, nb;
    logic [4:0]  exp_st;
    for (int it = 0; it < 10; it++) begin
      a  = (it % 3 == 0) ? 30'h3FFFFFFE : 30'($urandom);
      nb = 30'($urandom_range(1, 4) * 4);
      if ($urandom_range(0, 4) == 0) nb = (it % 2 == 0) ? 30'd0 : nb + 30'($urandom_range(1, 3));
      run_xfer(a, nb, 1, 0);
      exp_st = exp_err ? 5'b00100 : 5'b00010;
      checks++;
      if (timed_out !== 1'b0 || rd_ok() !== 1'b1)
        $display("FAIL rand_reads[%0d]: addr=%h nbytes=%0d got %0d reads (timeout=%b) required %0d", it, a, nb, rd_q.size(), timed_out, exp_rd.size());
      else passes++;
      checks++;
      if (fl_ok() !== 1'b1)
        $display("FAIL rand_flits[%0d]: got %0d flits required %0d", it, flit_q.size(), exp_fl.size());
      else passes++;
      checks++;
      if (status_out !== exp_st || n_done !== (exp_err ? 0 : 1) || n_err !== (exp_err ? 1 : 0))
        $display("FAIL rand_status[%0d]: got %b done=%0d err=%0d required %b", it, status_out, n_done, n_err, exp_st);
      else passes++;
    end
  endtask

  initial begin
    reset = 1'b1; cmd_in = 1'b0; addr_in = '0; nbytes_in = '0; flit_ready_in = 1'b1;
    mem[30'h10] = 32'hAAAA5555;
    mem[30'h11] = 32'h12345678;
    test_reset();
    test_basic();
    test_backpressure();
    test_errors();
    test_dropped();
    test_reset_wrap();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ddma_engine.md
DDMA_ENGINE -- requirements
Module: ddma_engine

Interface
REQ-001 SHALL have parameter MEMORY_BUS_WIDTH, default 32, meaning memory data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter FLIT_WIDTH, default 16, meaning NoC flit width in bits; it must divide MEMORY_BUS_WIDTH.
REQ-003 SHALL have port clock, input, 1 bit: single clock; all logic on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port addr_in, input, MEMORY_BUS_WIDTH-2 bits: word address of the first memory word.
REQ-006 SHALL have port nbytes_in, input, MEMORY_BUS_WIDTH-2 bits: transfer length in bytes.
REQ-007 SHALL have port cmd_in, input, 1 bit: one-cycle start pulse; addr_in and nbytes_in are sampled in the same cycle.
REQ-008 SHALL have port status_out, output, 5 bits: bit0 busy, bit1 done, bit2 error, bit3 dropped, bit4 always 0.
REQ-009 SHALL have port irq_out, output, 5 bits: one-cycle pulses, same bit positions as status_out; bit0 and bit4 are always 0.
REQ-010 SHALL have port mem_addr_out, output, MEMORY_BUS_WIDTH-2 bits: memory word read address.
REQ-011 SHALL have port mem_rd_out, output, 1 bit: read strobe; data returns on mem_data_in exactly 1 cycle later.
REQ-012 SHALL have port mem_data_in, input, MEMORY_BUS_WIDTH bits: memory read data.
REQ-013 SHALL have ports flit_out (output, FLIT_WIDTH bits), flit_valid_out (output, 1 bit) and flit_ready_in (input, 1 bit): NoC output, valid/ready handshake.

Function
REQ-014 SHALL implement FSM states IDLE, FETCH, WAIT, SEND, DONE.
REQ-015 SHALL, in IDLE on cmd_in=1, latch addr_in and nbytes_in, clear done/error/dropped, and go to FETCH.
REQ-016 SHALL flag error when nbytes_in=0 or nbytes_in is not a multiple of MEMORY_BUS_WIDTH/8: remain in IDLE, set error, pulse irq_out[2] the next cycle, issue no memory access.
REQ-017 SHALL, in FETCH, assert mem_rd_out for exactly one cycle with the current address, then go to WAIT.
REQ-018 SHALL, in WAIT, capture mem_data_in into the serializer and go to SEND.
REQ-019 SHALL, in SEND, present the word as MEMORY_BUS_WIDTH/FLIT_WIDTH flits, least-significant flit first; a flit is transferred when flit_valid_out and flit_ready_in are both 1.
REQ-020 SHALL hold flit_out stable and keep flit_valid_out high while flit_ready_in=0.
REQ-021 SHALL, after the last flit of a word, increment the address by 1 (wrapping modulo 2^(MEMORY_BUS_WIDTH-2)) and decrement the remaining word count; go to FETCH if words remain, else go to DONE.
REQ-022 SHALL, in DONE, set done, clear busy, pulse irq_out[1] for one cycle, and return to IDLE.
REQ-023 SHALL hold busy=1 in every state except IDLE.
REQ-024 SHALL ignore cmd_in while busy, set dropped, and pulse irq_out[3]; the ongoing transfer SHALL be unaffected.
REQ-025 SHALL keep done, error and dropped sticky until the next accepted cmd_in.
REQ-026 SHALL have a minimum latency of 3 cycles from cmd_in to the first flit_valid_out.

Reset
REQ-027 SHALL, on reset, enter IDLE and drive status_out=0, irq_out=0, mem_rd_out=0, mem_addr_out=0, flit_valid_out=0, flit_out=0.
REQ-028 SHALL, on reset mid-transfer, abandon the transfer with no done pulse; flit_valid_out drops in the cycle after reset is sampled.

Configuration
REQ-029 SHALL support macro DDMA_HEADER_EN.
- Defined: before the first payload flit, emit one header flit equal to the word count (nbytes/(MEMORY_BUS_WIDTH/8)) truncated to FLIT_WIDTH bits. This adds one state, HEADER, between the accepting IDLE cycle and FETCH, under the same handshake rules.
- Undefined: no header flit; payload only.

Structure
REQ-030 SHALL place the state enum and the status/irq bit-index constants in package ddma_pkg.
REQ-031 SHALL implement word-to-flit shifting in sub-module ddma_serializer (load, shift-on-handshake, last-flit flag).

Verification (defaults 32/16)
REQ-032 SHALL test a basic transfer: addr_in=0x10, nbytes_in=8, memory holds 0xAAAA5555 and 0x12345678 -> reads at 0x10 then 0x11; flits 0x5555, 0xAAAA, 0x5678, 0x1234; irq_out[1] pulses once; status_out=0b00010.
REQ-033 SHALL test backpressure: same transfer with flit_ready_in=0 for 5 cycles at the second flit -> flit_out is held at 0xAAAA; the flit sequence is unchanged.
REQ-034 SHALL test errors: nbytes_in=6 and nbytes_in=0 -> no mem_rd_out; irq_out[2] pulses; status_out=0b00100.
REQ-035 SHALL test a dropped command: cmd_in during SEND with addr_in=0x40 -> irq_out[3] pulses; the original transfer completes with addr 0x40 never read; status_out=0b01010.
REQ-036 SHALL test reset and wrap: reset asserted in WAIT -> all outputs are 0 next cycle, no done. Then addr_in=0x3FFFFFFF, nbytes_in=8 -> reads at 0x3FFFFFFF then 0x0.
REQ-037 SHALL test the header with DDMA_HEADER_EN defined: nbytes_in=8 -> first flit is 0x0002, followed by the 4 payload flits.
